dmem_port_arbiter: RTL and testbench

Shares the single-port data memory between the pipeline's MEM stage (CPU) and a secondary DMA/loader requester, for example a program loader or a PortIn capture engine. Arbitration is cycle-by-cycle with combinational grant. The CPU has priority, but a starvation counter guarantees DMA progress, and a burst limit bounds how long DMA can hold the memory. When the CPU loses arbitration, the block raises `cpu_stall`, which freezes PC, IF/ID, ID/EX and EX/MEM.

---
 rtl/dmem_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//
// Shares one single-port data memory between the CPU MEM stage and a
// DMA/loader requester. The grant is decided in the same cycle as the request.
// The CPU has priority, with two exceptions:
//   - a starvation counter forces a DMA grant after STARVE_LIMIT consecutive
//     CPU wins over a pending DMA request;
//   - once DMA owns the memory, it keeps it for up to MAX_BURST consecutive
//     grants, even if the CPU starts requesting.
// While the CPU is denied, cpu_stall freezes the pipeline front end.
//
// Ports
//   clk, reset              clock; asynchronous active-low reset
//   cpu_req/we/addr/wdata   MEM stage access (held while stalled)
//   cpu_rdata               combinational passthrough of mem_rdata
//   cpu_stall               CPU request not granted this cycle
//   dma_req/we/addr/wdata   DMA access (held until dma_gnt)
//   dma_gnt                 DMA access accepted this cycle
//   dma_rvalid, dma_rdata   registered read return, one cycle after the grant
//   mem_we/re/addr/wdata    memory control, muxed from the winner
//   mem_rdata               asynchronous memory read data
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 9,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MAX_BURST    = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,

    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_gnt,
    output logic                  dma_rvalid,
    output logic [DATA_WIDTH-1:0] dma_rdata,

    output logic                  mem_we,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned BURST_W  = $clog2(MAX_BURST + 1);
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [BURST_W-1:0]  BURST_MAX  = BURST_W'(MAX_BURST);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    // Arbitration state
    owner_t                r_owner;
    logic [BURST_W-1:0]    r_burst_cnt;
    logic [STARVE_W-1:0]   r_starve_cnt;
    logic                  r_dma_rvalid;
    logic [DATA_WIDTH-1:0] r_dma_rdata;

    // Grant decision
    logic w_dma_starved;
    logic w_burst_open;
    logic w_grant_dma;
    logic w_grant_cpu;
    logic w_dma_read;

    // DMA is forced after the CPU has beaten it STARVE_LIMIT times in a row
    assign w_dma_starved = (r_owner == OWN_CPU) && (r_starve_cnt == STARVE_MAX);

    // An ongoing DMA burst may continue until it reaches MAX_BURST grants
    assign w_burst_open  = (r_owner == OWN_DMA) && (r_burst_cnt < BURST_MAX);

    // Gating with reset makes every enable and grant drop as soon as reset is asserted
    assign w_grant_dma = reset && dma_req && (!cpu_req || w_dma_starved || w_burst_open);
    assign w_grant_cpu = reset && cpu_req && !w_grant_dma;
    assign w_dma_read  = w_grant_dma && !dma_we;

    // Memory port mux; with no grant the address and data follow the CPU
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = w_grant_cpu && cpu_we;
        mem_re    = w_grant_cpu && !cpu_we;
        if (w_grant_dma) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_we    = dma_we;
            mem_re    = !dma_we;
        end
    end

    // Owner, burst and starvation tracking plus registered DMA read return
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner      <= OWN_CPU;
            r_burst_cnt  <= '0;
            r_starve_cnt <= '0;
            r_dma_rvalid <= 1'b0;
            r_dma_rdata  <= '0;
        end else begin
            r_owner <= w_grant_dma ? OWN_DMA : OWN_CPU;

            // A lone DMA can stream past MAX_BURST, so the count saturates
            if (w_grant_dma) begin
                if (r_owner == OWN_DMA) begin
                    if (r_burst_cnt != BURST_MAX) begin
                        r_burst_cnt <= r_burst_cnt + BURST_W'(1);
                    end
                end else begin
                    r_burst_cnt <= BURST_W'(1);
                end
            end else begin
                r_burst_cnt <= '0;
            end

            if (w_grant_cpu && dma_req) begin
                if (r_starve_cnt != STARVE_MAX) begin
                    r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
                end
            end else begin
                r_starve_cnt <= '0;
            end

            r_dma_rvalid <= w_dma_read;
            if (w_dma_read) begin
                r_dma_rdata <= mem_rdata;
            end
        end
    end

    assign cpu_rdata  = mem_rdata;
    assign cpu_stall  = reset && cpu_req && !w_grant_cpu;
    assign dma_gnt    = w_grant_dma;
    assign dma_rvalid = r_dma_rvalid;
    assign dma_rdata  = r_dma_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_port_arbiter
//
// Drives the arbiter against a behavioural memory and a reference model.
// The model tracks run lengths (consecutive DMA grants, consecutive CPU wins
// over a waiting DMA) and a shadow copy of memory.
// -----------------------------------------------------------------------------
module tb_dmem_port_arbiter;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 32;
    localparam int unsigned MB = 4;
    localparam int unsigned SL = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_stall;
    logic          dma_req, dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_gnt, dma_rvalid;
    logic [DW-1:0] dma_rdata;
    logic          mem_we, mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    dmem_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .dma_rdata(dma_rdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port memory with asynchronous read
    logic [DW-1:0] mem [0:511];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    // Reference model state
    logic [DW-1:0] ref_mem [0:511];
    int unsigned   m_dma_run;
    int unsigned   m_cpu_run;
    logic          m_exp_rv;
    logic [DW-1:0] m_exp_rd;
    logic          m_last_gdma;
    logic          m_last_stall;
    logic          obs_gnt;
    logic          obs_stall;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_dma_run = 0;
        m_cpu_run = 0;
        m_exp_rv  = 1'b0;
        m_exp_rd  = '0;
        m_last_gdma  = 1'b0;
        m_last_stall = 1'b0;
    endtask

    // One arbitrated cycle: inputs are already driven; check combinational
    // outputs mid-cycle, then registered outputs just after the edge.
    task automatic tick();
        logic g_dma, g_cpu, e_we, e_re;
        #1;
        g_dma = dma_req && (!cpu_req
                            || (m_dma_run == 0 && m_cpu_run >= SL)
                            || (m_dma_run > 0 && m_dma_run < MB));
        g_cpu = cpu_req && !g_dma;
        e_we  = (g_dma && dma_we) || (g_cpu && cpu_we);
        e_re  = (g_dma && !dma_we) || (g_cpu && !cpu_we);
        obs_gnt   = dma_gnt;
        obs_stall = cpu_stall;
        chk("dma_gnt", 64'(dma_gnt), 64'(g_dma));
        chk("cpu_stall", 64'(cpu_stall), 64'(cpu_req && !g_cpu));
        chk("mem_we", 64'(mem_we), 64'(e_we));
        chk("mem_re", 64'(mem_re), 64'(e_re));
        if (g_dma || g_cpu) chk("mem_addr", 64'(mem_addr), 64'(g_dma ? dma_addr : cpu_addr));
        if (e_we) chk("mem_wdata", 64'(mem_wdata), 64'(g_dma ? dma_wdata : cpu_wdata));
        if (g_cpu && !cpu_we) chk("cpu_rdata", 64'(cpu_rdata), 64'(ref_mem[cpu_addr]));

        m_exp_rv = g_dma && !dma_we;
        if (m_exp_rv) m_exp_rd = ref_mem[dma_addr];
        if (g_dma && dma_we) ref_mem[dma_addr] = dma_wdata;
        if (g_cpu && cpu_we) ref_mem[cpu_addr] = cpu_wdata;
        m_dma_run = g_dma ? m_dma_run + 1 : 0;
        m_cpu_run = (g_cpu && dma_req) ? m_cpu_run + 1 : 0;
        m_last_gdma  = g_dma;
        m_last_stall = cpu_req && !g_cpu;

        @(posedge clk);
        #1;
        chk("dma_rvalid", 64'(dma_rvalid), 64'(m_exp_rv));
        chk("dma_rdata", 64'(dma_rdata), 64'(m_exp_rd));
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    endtask

    initial begin
        logic [10:0] gnt_seq;
        int          stall_cnt;
        int          dma_wait;
        int          stall_run;

        for (int i = 0; i < 512; i++) begin
            mem[i]     = 32'h1000_0000 + 32'(i);
            ref_mem[i] = 32'h1000_0000 + 32'(i);
        end
        mem[7]     = 32'h1234_5678;
        ref_mem[7] = 32'h1234_5678;
        model_reset();

        // Reset with all requests high
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'd1; cpu_wdata = 32'hAAAA_0001;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 9'd2; dma_wdata = 32'hBBBB_0002;
        #1;
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_re", 64'(mem_re), 64'd0);
        chk("rst_dma_gnt", 64'(dma_gnt), 64'd0);
        chk("rst_cpu_stall", 64'(cpu_stall), 64'd0);
        chk("rst_dma_rvalid", 64'(dma_rvalid), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        chk("rst_dma_rdata", 64'(dma_rdata), 64'd0);
        reset = 1'b1;
        dma_req = 1'b0;
        tick();
        chk("first_cpu_win", 64'(obs_stall), 64'd0);

        // CPU only: write then read back address 5
        idle_inputs();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'd5; cpu_wdata = 32'hDEAD_BEEF;
        tick();
        chk("cpu_wr_stall", 64'(obs_stall), 64'd0);
        cpu_we = 1'b0;
        tick();
        chk("cpu_rd_stall", 64'(obs_stall), 64'd0);
        chk("cpu_rd_data", 64'(cpu_rdata), 64'hDEAD_BEEF);
        idle_inputs();
        tick();

        // Contention from CPU ownership
        cpu_req = 1'b1; cpu_addr = 9'd20;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 9'd30;
        gnt_seq   = '0;
        stall_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            dma_wdata = 32'hC0DE_0000 + 32'(i);
            tick();
            gnt_seq[10 - i] = obs_gnt;
            if (i < 7 && obs_stall) stall_cnt++;
        end
        chk("contention_seq", 64'(gnt_seq), 64'(11'b000_1111_0001));
        chk("contention_stalls", 64'(stall_cnt), 64'd4);
        idle_inputs();
        tick();

        // DMA read of address 7 with the CPU idle
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 9'd7;
        tick();
        chk("dmard_gnt", 64'(obs_gnt), 64'd1);
        chk("dmard_rvalid", 64'(dma_rvalid), 64'd1);
        chk("dmard_rdata", 64'(dma_rdata), 64'h1234_5678);
        idle_inputs();
        tick();
        chk("dmard_pulse", 64'(dma_rvalid), 64'd0);
        tick();

        // CPU arrives after two DMA grants
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 9'd40;
        tick();
        dma_addr = 9'd41;
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'd5;
        stall_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            dma_addr = 9'(42 + i);
            tick();
            if (obs_stall) stall_cnt++;
        end
        chk("midburst_stalls", 64'(stall_cnt), 64'd2);
        chk("midburst_cpu_win", 64'(obs_gnt), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("starve_count_cpu", 64'(obs_stall), 64'(i == 2));
        end
        idle_inputs();
        tick();

        // Reset dropped mid-burst during a DMA write
        dma_req = 1'b1; dma_we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dma_addr = 9'(60 + i); dma_wdata = 32'hFEED_0000 + 32'(i);
            tick();
        end
        dma_addr = 9'd63; dma_wdata = 32'hFEED_0003;
        #1;
        chk("pre_rst_mem_we", 64'(mem_we), 64'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst_mem_we", 64'(mem_we), 64'd0);
        chk("async_rst_dma_gnt", 64'(dma_gnt), 64'd0);
        model_reset();
        @(posedge clk); #1;
        chk("async_rst_no_write", 64'(mem[63]), 64'(ref_mem[63]));
        chk("async_rst_rvalid", 64'(dma_rvalid), 64'd0);
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'd61;
        tick();
        chk("post_rst_cpu_win", 64'(obs_gnt), 64'd0);
        chk("post_rst_rdata", 64'(cpu_rdata), 64'(32'hFEED_0001));
        idle_inputs();
        tick();

        // Randomized traffic; stalled CPU and pending DMA requests are held
        dma_wait  = 0;
        stall_run = 0;
        for (int i = 0; i < 400; i++) begin
            if (!m_last_stall) begin
                cpu_req   = ($urandom_range(0, 9) < 6);
                cpu_we    = $urandom_range(0, 1) == 1;
                cpu_addr  = 9'($urandom_range(0, 15));
                cpu_wdata = $urandom;
            end
            if (dma_req && !m_last_gdma) begin
                if ($urandom_range(0, 15) == 0) dma_req = 1'b0;
            end else begin
                dma_req   = ($urandom_range(0, 1) == 1);
                dma_we    = $urandom_range(0, 1) == 1;
                dma_addr  = 9'($urandom_range(0, 15));
                dma_wdata = $urandom;
            end
            tick();
            dma_wait  = (dma_req && !obs_gnt) ? dma_wait + 1 : 0;
            stall_run = obs_stall ? stall_run + 1 : 0;
            if (dma_wait > int'(SL)) chk("dma_wait_bound", 64'(dma_wait), 64'(SL));
            if (stall_run > int'(MB)) chk("cpu_stall_bound", 64'(stall_run), 64'(MB));
        end
        idle_inputs();
        tick();
        for (int a = 0; a < 16; a++) begin
            chk("final_mem", 64'(mem[a]), 64'(ref_mem[a]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
